raizing_gfx_rom_arb: RTL and testbench

//  Graphics-ROM request arbiter feeding the video subsystem's OBJ and SCR0/1/2 32-bit ROM ports.

---
 rtl/raizing_gfx_pkg.sv | 28 ++
 rtl/raizing_rr_arb4.sv | 21 ++
 rtl/raizing_gfx_rom_arb.sv | 125 ++++++++++++
 tb/tb_raizing_gfx_rom_arb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raizing_gfx_pkg.sv
// Raizing graphics-ROM arbiter shared definitions.
// States, requester indices and default widths.
package raizing_gfx_pkg;

  localparam int AW_DEF = 22;
  localparam int DW_DEF = 32;
  localparam int NRQ    = 4;

  localparam logic [1:0] RQ_OBJ  = 2'd0;
  localparam logic [1:0] RQ_SCR0 = 2'd1;
  localparam logic [1:0] RQ_SCR1 = 2'd2;
  localparam logic [1:0] RQ_SCR2 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Requester index k steps after ptr, wrapping mod 4.
  function automatic logic [1:0] rr_idx(
    input logic [1:0] ptr,
    input int         k
  );
    return ptr + 2'(k);
  endfunction

endpackage

// File: rtl/raizing_rr_arb4.sv
// Four-way round-robin picker.
// Scans PTR+1, PTR+2, ... and grants the first missing requester.
module raizing_rr_arb4
  import raizing_gfx_pkg::*;
(
  input  logic [1:0] PTR,
  input  logic [3:0] MISS,
  output logic [1:0] GNT,
  output logic       ANY
);

  // Scan farthest-first so the nearest candidate after PTR wins.
  always_comb begin
    GNT = PTR;
    ANY = |MISS;
    for (int k = 4; k >= 1; k--) begin
      if (MISS[rr_idx(PTR, k)]) GNT = rr_idx(PTR, k);
    end
  end

endmodule

// File: rtl/raizing_gfx_rom_arb.sv
// Graphics-ROM request arbiter: four buffered requesters
// share one SDRAM read port in round-robin order.
module raizing_gfx_rom_arb
  import raizing_gfx_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            FLUSH,
  input  logic [3:0]      REQ_CS,
  input  logic [4*AW-1:0] REQ_ADDR,
  output logic [3:0]      REQ_OK,
  output logic [4*DW-1:0] REQ_DOUT,
  output logic            SDRAM_REQ,
  output logic [AW-1:0]   SDRAM_ADDR,
  input  logic            SDRAM_ACK,
  input  logic            SDRAM_DST,
  input  logic [DW-1:0]   SDRAM_DOUT
);

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_gnt;
  logic            r_drop;
  logic [AW-1:0]   r_laddr;
  logic            r_sdram_req;
  logic [AW-1:0]   r_sdram_addr;
  logic [NRQ-1:0]  r_valid;
  logic [AW-1:0]   r_tag  [NRQ];
  logic [DW-1:0]   r_data [NRQ];

  logic [AW-1:0]   w_addr [NRQ];
  logic [NRQ-1:0]  w_hit;
  logic [NRQ-1:0]  w_miss;
  logic [1:0]      w_gnt;
  logic            w_any;
  logic            w_done;
  logic            w_fill;

  genvar g;
  for (g = 0; g < NRQ; g++) begin : g_rq
    assign w_addr[g] = REQ_ADDR[g*AW +: AW];
    assign w_hit[g]  = r_valid[g] & (r_tag[g] == w_addr[g]);
    assign REQ_DOUT[g*DW +: DW] = r_data[g];
  end

  assign w_miss = REQ_CS & ~w_hit;
  assign REQ_OK = REQ_CS & w_hit;

  assign SDRAM_REQ  = r_sdram_req;
  assign SDRAM_ADDR = r_sdram_addr;

  // Fetch completes on DST in WAIT, or on ACK+DST together in REQ.
  assign w_done = SDRAM_DST &
                  ((r_state == ST_WAIT) |
                   ((r_state == ST_REQ) & SDRAM_ACK));

  // A flush now or earlier in the fetch throws the data away.
  assign w_fill = w_done & ~r_drop & ~FLUSH;

  raizing_rr_arb4 u_arb (
    .PTR  (r_ptr),
    .MISS (w_miss),
    .GNT  (w_gnt),
    .ANY  (w_any)
  );

  // Fetch FSM plus the per-requester tag/data buffers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_ptr        <= RQ_SCR2;
      r_gnt        <= RQ_OBJ;
      r_drop       <= 1'b0;
      r_laddr      <= '0;
      r_sdram_req  <= 1'b0;
      r_sdram_addr <= '0;
      r_valid      <= '0;
      for (int i = 0; i < NRQ; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt        <= w_gnt;
            r_laddr      <= w_addr[w_gnt];
            r_sdram_addr <= w_addr[w_gnt];
            r_sdram_req  <= 1'b1;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (SDRAM_ACK) begin
            r_sdram_req <= 1'b0;
            r_state     <= SDRAM_DST ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (SDRAM_DST) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_fill) begin
        r_tag[r_gnt]   <= r_laddr;
        r_data[r_gnt]  <= SDRAM_DOUT;
        r_valid[r_gnt] <= 1'b1;
      end

      if (w_done) begin
        r_ptr  <= r_gnt;
        r_drop <= 1'b0;
      end else if (FLUSH && r_state != ST_IDLE) begin
        r_drop <= 1'b1;
      end

      if (FLUSH) r_valid <= '0;
    end
  end

endmodule

// File: tb/tb_raizing_gfx_rom_arb.sv
// Directed bench for raizing_gfx_rom_arb.
// Table of hit/miss vectors plus fetch sequences.
module tb_raizing_gfx_rom_arb;
  import raizing_gfx_pkg::*;

  localparam int AW = 22;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            clk_run = 1'b1;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [3:0]      cs = 4'h0;
  logic [AW-1:0]   a [4];
  logic [4*AW-1:0] req_addr;
  logic [3:0]      req_ok;
  logic [4*DW-1:0] req_dout;
  logic            sd_req;
  logic [AW-1:0]   sd_addr;
  logic            ack = 1'b0;
  logic            dst = 1'b0;
  logic [DW-1:0]   sd_dout = '0;

  int n_cmp = 0;
  int n_bad = 0;

  assign req_addr = {a[3], a[2], a[1], a[0]};

  always #5 if (clk_run) clk = ~clk;

  raizing_gfx_rom_arb #(.AW(AW), .DW(DW)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .FLUSH      (flush),
    .REQ_CS     (cs),
    .REQ_ADDR   (req_addr),
    .REQ_OK     (req_ok),
    .REQ_DOUT   (req_dout),
    .SDRAM_REQ  (sd_req),
    .SDRAM_ADDR (sd_addr),
    .SDRAM_ACK  (ack),
    .SDRAM_DST  (dst),
    .SDRAM_DOUT (sd_dout)
  );

  typedef struct packed {
    logic [3:0]      cs;
    logic [4*AW-1:0] addr;
    logic [3:0]      ok;
  } vec_t;

  vec_t vt [8];

  function automatic logic [DW-1:0] dfun(input logic [AW-1:0] ad);
    if (ad == 22'h000100) return 32'hDEADBEEF;
    return {10'h155, ad};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(output logic [AW-1:0] ad);
    int n = 0;
    while (sd_req !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    if (sd_req !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got SDRAM_REQ=%b want 1", sd_req);
    end
    ad = sd_addr;
  endtask

  task automatic pulse_ack(input logic with_dst, input logic [DW-1:0] d);
    ack = 1'b1;
    if (with_dst) begin
      dst = 1'b1;
      sd_dout = d;
    end
    tick;
    ack = 1'b0;
    dst = 1'b0;
  endtask

  task automatic pulse_dst(input logic [DW-1:0] d);
    dst = 1'b1;
    sd_dout = d;
    tick;
    dst = 1'b0;
  endtask

  // Serve one fetch: ACK one cycle after REQ, DST gap cycles after ACK.
  task automatic serve(input string nm, input int gap,
                       input logic [AW-1:0] exp);
    logic [AW-1:0] ad;
    wait_req(ad);
    chk(nm, 128'(ad), 128'(exp));
    tick;
    pulse_ack(gap == 0, dfun(ad));
    if (gap > 0) begin
      repeat (gap - 1) tick;
      pulse_dst(dfun(ad));
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cs = 4'h0;
    tick;
    rst_n = 1'b1;
  endtask

  localparam logic [AW-1:0] A0 = 22'h000300;
  localparam logic [AW-1:0] A1 = 22'h001100;
  localparam logic [AW-1:0] A2 = 22'h002100;
  localparam logic [AW-1:0] A3 = 22'h003100;

  logic [AW-1:0]   ad;
  logic [4*DW-1:0] eb;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) a[i] = '0;

    // 1: reset with every CS asserted
    cs = 4'hF;
    tick;
    tick;
    chk("rst_ok", 128'(req_ok), 128'h0);
    chk("rst_sreq", 128'(sd_req), 128'h0);
    chk("rst_saddr", 128'(sd_addr), 128'h0);
    chk("rst_dout", 128'(req_dout), 128'h0);
    cs = 4'h1;
    a[0] = 22'h000100;
    rst_n = 1'b1;
    #1;
    chk("rel_sreq0", 128'(sd_req), 128'h0);
    tick;
    chk("rel_sreq1", 128'(sd_req), 128'h1);
    chk("rel_saddr", 128'(sd_addr), 128'h100);

    // 2: hit path then address change
    serve("t2_fill", 3, 22'h000100);
    chk("t2_ok", 128'(req_ok), 128'h1);
    chk("t2_dout", 128'(req_dout[31:0]), 128'hDEADBEEF);
    repeat (3) tick;
    chk("t2_nosreq", 128'(sd_req), 128'h0);
    a[0] = 22'h000104;
    #1;
    chk("t2_okdrop", 128'(req_ok), 128'h0);
    tick;
    chk("t2_sreq", 128'(sd_req), 128'h1);
    serve("t2_refill", 2, 22'h000104);
    chk("t2_ok2", 128'(req_ok), 128'h1);
    chk("t2_dout2", 128'(req_dout[31:0]), 128'(dfun(22'h000104)));

    // 3: round-robin from reset pointer
    do_reset;
    a[0] = A0; a[1] = A1; a[2] = A2; a[3] = A3;
    cs = 4'hF;
    serve("rr0", 3, A0);
    chk("rr0_ok", 128'(req_ok), 128'h1);
    serve("rr1", 3, A1);
    chk("rr1_ok", 128'(req_ok), 128'h3);
    serve("rr2", 3, A2);
    chk("rr2_ok", 128'(req_ok), 128'h7);
    serve("rr3", 3, A3);
    chk("rr3_ok", 128'(req_ok), 128'hF);
    eb = {dfun(A3), dfun(A2), dfun(A1), dfun(A0)};
    chk("rr_dout", 128'(req_dout), 128'(eb));

    // Hit/miss table, evaluated with the clock held low
    vt[0] = '{cs: 4'hF, addr: {A3, A2, A1, A0}, ok: 4'hF};
    vt[1] = '{cs: 4'h0, addr: {A3, A2, A1, A0}, ok: 4'h0};
    vt[2] = '{cs: 4'h5, addr: {A3, A2, A1, A0}, ok: 4'h5};
    vt[3] = '{cs: 4'hF, addr: {A3, A2, 22'h1104, A0}, ok: 4'hD};
    vt[4] = '{cs: 4'hF, addr: {A3, A2, A1, A1}, ok: 4'hE};
    vt[5] = '{cs: 4'hA, addr: {22'h3104, A2, A1, A0}, ok: 4'h2};
    vt[6] = '{cs: 4'hF, addr: {A0, A1, A2, A3}, ok: 4'h0};
    vt[7] = '{cs: 4'h8, addr: {A3, A0, A0, A0}, ok: 4'h8};
    clk_run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cs = vt[i].cs;
      for (int j = 0; j < 4; j++) a[j] = vt[i].addr[j*AW +: AW];
      #1;
      chk($sformatf("vec%0d_ok", i), 128'(req_ok), 128'(vt[i].ok));
      chk($sformatf("vec%0d_dout", i), 128'(req_dout), 128'(eb));
    end
    cs = 4'hF;
    a[0] = A0; a[1] = A1; a[2] = A2; a[3] = A3;
    #1;
    clk_run = 1'b1;
    @(negedge clk);
    tick;
    chk("vec_idle", 128'(sd_req), 128'h0);

    // Re-miss on OBJ and SCR2 with PTR=3: OBJ first, then wrap
    a[0] = 22'h000304;
    a[3] = 22'h003104;
    serve("wrap0", 3, 22'h000304);
    serve("wrap1", 3, 22'h003104);
    a[0] = 22'h000308;
    serve("wrap2", 1, 22'h000308);
    a[0] = 22'h00030C;
    a[2] = 22'h002104;
    serve("ptr0_scr1", 1, 22'h002104);
    serve("ptr0_obj", 1, 22'h00030C);
    chk("wrap_ok", 128'(req_ok), 128'hF);

    // 4: address change while the fetch is in WAIT
    a[2] = 22'h002000;
    wait_req(ad);
    chk("mid_addr", 128'(ad), 128'h2000);
    tick;
    pulse_ack(1'b0, '0);
    a[2] = 22'h002004;
    tick;
    pulse_dst(dfun(22'h002000));
    chk("mid_ok", 128'(req_ok), 128'hB);
    chk("mid_dout", 128'(req_dout[2*DW +: DW]), 128'(dfun(22'h002000)));
    serve("mid_refetch", 2, 22'h002004);
    chk("mid_ok2", 128'(req_ok), 128'hF);

    // 5a: FLUSH in WAIT in the same cycle as DST
    a[1] = 22'h001200;
    wait_req(ad);
    chk("fl_addr", 128'(ad), 128'h1200);
    tick;
    pulse_ack(1'b0, '0);
    tick;
    flush = 1'b1;
    dst = 1'b1;
    sd_dout = dfun(22'h001200);
    tick;
    flush = 1'b0;
    dst = 1'b0;
    chk("fl_ok", 128'(req_ok), 128'h0);
    chk("fl_dout1", 128'(req_dout[DW +: DW]), 128'(dfun(A1)));
    serve("fl_r0", 1, 22'h002004);
    serve("fl_r1", 1, 22'h003104);
    serve("fl_r2", 1, 22'h00030C);
    chk("fl_ok3", 128'(req_ok), 128'hD);
    serve("fl_r3", 1, 22'h001200);
    chk("fl_ok4", 128'(req_ok), 128'hF);
    chk("fl_dout1b", 128'(req_dout[DW +: DW]), 128'(dfun(22'h001200)));

    // 5b: FLUSH in WAIT one cycle before DST
    a[0] = 22'h000400;
    wait_req(ad);
    chk("fl2_addr", 128'(ad), 128'h400);
    tick;
    pulse_ack(1'b0, '0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl2_ok", 128'(req_ok), 128'h0);
    pulse_dst(dfun(22'h000400));
    chk("fl2_ok2", 128'(req_ok), 128'h0);
    chk("fl2_dout0", 128'(req_dout[31:0]), 128'(dfun(22'h00030C)));
    serve("fl2_r0", 1, 22'h001200);
    serve("fl2_r1", 1, 22'h002004);
    serve("fl2_r2", 1, 22'h003104);
    chk("fl2_ok3", 128'(req_ok), 128'hE);
    serve("fl2_r3", 1, 22'h000400);
    chk("fl2_ok4", 128'(req_ok), 128'hF);
    chk("fl2_dout0b", 128'(req_dout[31:0]), 128'(dfun(22'h000400)));

    // 6: ACK and DST together, then stray pulses in IDLE
    a[2] = 22'h002200;
    serve("ad_same", 0, 22'h002200);
    chk("ad_ok", 128'(req_ok), 128'hF);
    chk("ad_sreq", 128'(sd_req), 128'h0);
    chk("ad_dout2", 128'(req_dout[2*DW +: DW]), 128'(dfun(22'h002200)));
    eb = {dfun(22'h003104), dfun(22'h002200),
          dfun(22'h001200), dfun(22'h000400)};
    ack = 1'b1;
    tick;
    ack = 1'b0;
    dst = 1'b1;
    sd_dout = 32'hBAD0BAD0;
    tick;
    dst = 1'b0;
    tick;
    chk("stray_sreq", 128'(sd_req), 128'h0);
    chk("stray_ok", 128'(req_ok), 128'hF);
    chk("stray_dout", 128'(req_dout), 128'(eb));
    a[3] = 22'h003300;
    serve("stray_next", 2, 22'h003300);
    chk("stray_ok2", 128'(req_ok), 128'hF);
    chk("stray_dout3", 128'(req_dout[3*DW +: DW]), 128'(dfun(22'h003300)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
